// File: rtl/lc_tx_sync_chk.sv
// lc_tx_sync_chk: multi-channel synchroniser, stability filter and encoding
// check for multi-bit life-cycle enables. Every channel fails safe to OFF_VAL.
// Optional feature macro: LC_TX_SYNC_CHK_STICKY_ERR_EN adds err_clr_i and
// err_sticky_o, a sticky OR of all per-channel invalid flags.
// Reset asserts asynchronously; release is expected to be synchronised upstream.

// Per-channel lane: flop chain, run-length filter, accept/encode check.
module lc_tx_sync_chk_lane #(
    parameter int              WIDTH      = 4,
    parameter logic [WIDTH-1:0] ON_VAL    = 4'hA,
    parameter logic [WIDTH-1:0] OFF_VAL   = 4'h5,
    parameter int              STAGES     = 2,
    parameter int              STABLE_CYC = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] lc_en_i,
    output logic [WIDTH-1:0] lc_en_o,
    output logic             invalid_o,
    output logic             invalid_d
);
    localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             sync;
    logic [WIDTH-1:0]             cand_q, cand_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [WIDTH-1:0]             en_d;

    assign sync = sync_q[STAGES-1];

    // Synchroniser chain; stage 0 samples the asynchronous input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= {STAGES{OFF_VAL}};
        else         sync_q <= {sync_q[STAGES-2:0], lc_en_i};
    end

    // Filter: any change in sync restarts the count; a full run of equal
    // samples accepts the candidate, and the count then saturates so the
    // same value keeps being re-accepted (harmless, output unchanged).
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        en_d      = lc_en_o;
        invalid_d = invalid_o;
        if (sync != cand_q) begin
            cand_d = sync;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else if (cand_q == ON_VAL) begin
            en_d      = ON_VAL;
            invalid_d = 1'b0;
        end else if (cand_q == OFF_VAL) begin
            en_d      = OFF_VAL;
            invalid_d = 1'b0;
        end else begin
            // Unknown encoding never enables anything downstream.
            en_d      = OFF_VAL;
            invalid_d = 1'b1;
        end
    end

    // Filter and output registers; outputs are driven directly by flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cand_q    <= OFF_VAL;
            cnt_q     <= '0;
            lc_en_o   <= OFF_VAL;
            invalid_o <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            lc_en_o   <= en_d;
            invalid_o <= invalid_d;
        end
    end
endmodule

// Top: NUM_CH independent lanes, optional sticky error aggregation.
module lc_tx_sync_chk #(
    parameter int              WIDTH      = 4,
    parameter int              NUM_CH     = 1,
    parameter logic [WIDTH-1:0] ON_VAL    = 4'hA,
    parameter logic [WIDTH-1:0] OFF_VAL   = 4'h5,
    parameter int              STAGES     = 2,
    parameter int              STABLE_CYC = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH*WIDTH-1:0] lc_en_i,
    output logic [NUM_CH*WIDTH-1:0] lc_en_o,
    output logic [NUM_CH-1:0]       invalid_o
`ifdef LC_TX_SYNC_CHK_STICKY_ERR_EN
    ,
    input  logic                    err_clr_i,
    output logic                    err_sticky_o
`endif
);
    logic [NUM_CH-1:0] inv_nxt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        lc_tx_sync_chk_lane #(
            .WIDTH      (WIDTH),
            .ON_VAL     (ON_VAL),
            .OFF_VAL    (OFF_VAL),
            .STAGES     (STAGES),
            .STABLE_CYC (STABLE_CYC)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .lc_en_i   (lc_en_i[c*WIDTH +: WIDTH]),
            .lc_en_o   (lc_en_o[c*WIDTH +: WIDTH]),
            .invalid_o (invalid_o[c]),
            .invalid_d (inv_nxt[c])
        );
    end

`ifdef LC_TX_SYNC_CHK_STICKY_ERR_EN
    // Sticky error tracks the post-update invalid flags; a set beats a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        err_sticky_o <= 1'b0;
        else if (|inv_nxt)  err_sticky_o <= 1'b1;
        else if (err_clr_i) err_sticky_o <= 1'b0;
    end
`else
    logic unused_inv_nxt;
    assign unused_inv_nxt = ^inv_nxt;
`endif
endmodule

// File: tb/tb_lc_tx_sync_chk.sv
// Self-checking bench for lc_tx_sync_chk (3 channels, default timing).
// The reference model tracks the run length of each channel's delayed input
// stream and accepts a value once it has been seen STB+1 times in a row.
module tb_lc_tx_sync_chk;
    localparam int W   = 4;
    localparam int NCH = 3;
    localparam int STG = 2;
    localparam int STB = 2;
    localparam logic [W-1:0] ON  = 4'hA;
    localparam logic [W-1:0] OFF = 4'h5;
    localparam logic [NCH*W-1:0] ALL_ON  = {NCH{ON}};
    localparam logic [NCH*W-1:0] ALL_OFF = {NCH{OFF}};

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NCH*W-1:0]   lc_en = '0;
    logic [NCH*W-1:0]   lc_en_o;
    logic [NCH-1:0]     invalid_o;
`ifdef LC_TX_SYNC_CHK_STICKY_ERR_EN
    logic               err_clr = 1'b0;
    logic               err_sticky_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc_tx_sync_chk #(
        .WIDTH(W), .NUM_CH(NCH), .ON_VAL(ON), .OFF_VAL(OFF),
        .STAGES(STG), .STABLE_CYC(STB)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .lc_en_i   (lc_en),
        .lc_en_o   (lc_en_o),
        .invalid_o (invalid_o)
`ifdef LC_TX_SYNC_CHK_STICKY_ERR_EN
        ,
        .err_clr_i    (err_clr),
        .err_sticky_o (err_sticky_o)
`endif
    );

    // ---------------- reference model ----------------
    logic [W-1:0] hist    [NCH][STG];
    logic [W-1:0] run_val [NCH];
    int           run_len [NCH];
    logic [W-1:0] m_out   [NCH];
    logic         m_inv   [NCH];
    logic         m_sticky;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < STG; k++) hist[c][k] = OFF;
            run_val[c] = OFF;
            run_len[c] = 1;
            m_out[c]   = OFF;
            m_inv[c]   = 1'b0;
        end
        m_sticky = 1'b0;
    endtask

    // Called right at a rising edge, before inputs change.
    task automatic model_step();
        logic [W-1:0] f;
        for (int c = 0; c < NCH; c++) begin
            f = hist[c][STG-1];
            for (int k = STG-1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = lc_en[c*W +: W];
            if (f == run_val[c]) begin
                if (run_len[c] < 1000) run_len[c]++;
            end else begin
                run_val[c] = f;
                run_len[c] = 1;
            end
            if (run_len[c] >= STB + 1) begin
                m_out[c] = (run_val[c] == ON) ? ON : OFF;
                m_inv[c] = (run_val[c] != ON) && (run_val[c] != OFF);
            end
        end
`ifdef LC_TX_SYNC_CHK_STICKY_ERR_EN
        begin
            logic any_inv;
            any_inv = 1'b0;
            for (int c = 0; c < NCH; c++) any_inv |= m_inv[c];
            if (any_inv)      m_sticky = 1'b1;
            else if (err_clr) m_sticky = 1'b0;
        end
`endif
    endtask

    function automatic logic [NCH*W-1:0] exp_en();
        logic [NCH*W-1:0] r;
        for (int c = 0; c < NCH; c++) r[c*W +: W] = m_out[c];
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_inv();
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = m_inv[c];
        return r;
    endfunction

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        lc_en = ALL_ON;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (lc_en_o !== ALL_OFF) begin
                errors++;
                $display("FAIL reset_en: got %h want %h", lc_en_o, ALL_OFF);
            end
            checks++;
            if (invalid_o !== '0) begin
                errors++;
                $display("FAIL reset_inv: got %b want 0", invalid_o);
            end
        end
`ifdef LC_TX_SYNC_CHK_STICKY_ERR_EN
        checks++;
        if (err_sticky_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_sticky: got %b want 0", err_sticky_o);
        end
`endif
        lc_en = ALL_OFF;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        lc_en = ALL_OFF;
        repeat (6) tick();
        lc_en = ALL_ON;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (lc_en_o !== ((e >= 5) ? ALL_ON : ALL_OFF)) begin
                errors++;
                $display("FAIL latency_edge%0d: got %h want %h", e, lc_en_o,
                         (e >= 5) ? ALL_ON : ALL_OFF);
            end
            checks++;
            if (lc_en_o !== exp_en()) begin
                errors++;
                $display("FAIL latency_model%0d: got %h want %h", e, lc_en_o, exp_en());
            end
        end
    endtask

    task automatic test_glitch();
        logic seen_on;
        lc_en = ALL_OFF;
        repeat (8) tick();
        lc_en = ALL_ON;
        repeat (2) tick();
        lc_en = ALL_OFF;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (lc_en_o !== ALL_OFF) begin
                errors++;
                $display("FAIL glitch2_cyc%0d: got %h want %h", i, lc_en_o, ALL_OFF);
            end
        end
        seen_on = 1'b0;
        lc_en = ALL_ON;
        repeat (3) begin
            tick();
            if (lc_en_o === ALL_ON) seen_on = 1'b1;
        end
        lc_en = ALL_OFF;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (lc_en_o === ALL_ON) seen_on = 1'b1;
        end
        checks++;
        if (seen_on !== 1'b1) begin
            errors++;
            $display("FAIL glitch3_pass: got seen=%b want 1", seen_on);
        end
        checks++;
        if (lc_en_o !== ALL_OFF) begin
            errors++;
            $display("FAIL glitch3_return: got %h want %h", lc_en_o, ALL_OFF);
        end
    endtask

    task automatic test_invalid();
        lc_en = {NCH{4'h3}};
        repeat (8) tick();
        checks++;
        if (lc_en_o !== ALL_OFF || invalid_o !== {NCH{1'b1}}) begin
            errors++;
            $display("FAIL invalid_set: got en=%h inv=%b want en=%h inv=111",
                     lc_en_o, invalid_o, ALL_OFF);
        end
        lc_en = ALL_ON;
        repeat (8) tick();
        checks++;
        if (lc_en_o !== ALL_ON || invalid_o !== '0) begin
            errors++;
            $display("FAIL invalid_clear: got en=%h inv=%b want en=%h inv=000",
                     lc_en_o, invalid_o, ALL_ON);
        end
    endtask

    task automatic test_multich();
        lc_en = {4'hF, OFF, ON};
        repeat (8) tick();
        checks++;
        if (lc_en_o !== 12'h55A || invalid_o !== 3'b100) begin
            errors++;
            $display("FAIL multich_static: got en=%h inv=%b want en=55a inv=100",
                     lc_en_o, invalid_o);
        end
        for (int i = 0; i < 20; i++) begin
            lc_en[7:4] = (i % 2 == 0) ? ON : OFF;
            tick();
            checks++;
            if (lc_en_o !== 12'h55A || invalid_o !== 3'b100) begin
                errors++;
                $display("FAIL multich_toggle%0d: got en=%h inv=%b want en=55a inv=100",
                         i, lc_en_o, invalid_o);
            end
        end
        lc_en = ALL_OFF;
        repeat (8) tick();
    endtask

    task automatic test_async_reset();
        lc_en = ALL_ON;
        repeat (8) tick();
        lc_en = ALL_OFF;
        repeat (3) tick();
        checks++;
        if (lc_en_o !== ALL_ON) begin
            errors++;
            $display("FAIL areset_pre: got %h want %h", lc_en_o, ALL_ON);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (lc_en_o !== ALL_OFF || invalid_o !== '0) begin
            errors++;
            $display("FAIL areset_immediate: got en=%h inv=%b want en=%h inv=000",
                     lc_en_o, invalid_o, ALL_OFF);
        end
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
    endtask

`ifdef LC_TX_SYNC_CHK_STICKY_ERR_EN
    task automatic test_sticky();
        err_clr = 1'b0;
        lc_en = ALL_OFF;
        repeat (8) tick();
        lc_en[3:0] = 4'h3;
        repeat (8) tick();
        checks++;
        if (invalid_o !== 3'b001 || err_sticky_o !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set: got inv=%b st=%b want inv=001 st=1",
                     invalid_o, err_sticky_o);
        end
        lc_en[3:0] = ON;
        repeat (8) tick();
        checks++;
        if (invalid_o !== 3'b000 || err_sticky_o !== 1'b1) begin
            errors++;
            $display("FAIL sticky_hold: got inv=%b st=%b want inv=000 st=1",
                     invalid_o, err_sticky_o);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_sticky_o !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: got %b want 0", err_sticky_o);
        end
        // New invalid accepted on the fifth edge, same edge as the clear.
        lc_en[3:0] = 4'h3;
        repeat (4) tick();
        checks++;
        if (err_sticky_o !== 1'b0 || invalid_o !== 3'b000) begin
            errors++;
            $display("FAIL sticky_pre: got inv=%b st=%b want inv=000 st=0",
                     invalid_o, err_sticky_o);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_sticky_o !== 1'b1 || invalid_o !== 3'b001) begin
            errors++;
            $display("FAIL sticky_set_wins: got inv=%b st=%b want inv=001 st=1",
                     invalid_o, err_sticky_o);
        end
        lc_en = ALL_OFF;
        repeat (8) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask
`endif

    task automatic test_random();
        int hold [NCH];
        int r;
        for (int c = 0; c < NCH; c++) hold[c] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold[c] == 0) begin
                    r = $urandom_range(0, 3);
                    case (r)
                        0:       lc_en[c*W +: W] = ON;
                        1:       lc_en[c*W +: W] = OFF;
                        2:       lc_en[c*W +: W] = W'($urandom);
                        default: ;
                    endcase
                    hold[c] = $urandom_range(1, 5);
                end
                hold[c]--;
            end
`ifdef LC_TX_SYNC_CHK_STICKY_ERR_EN
            err_clr = ($urandom_range(0, 7) == 0);
`endif
            tick();
            checks++;
            if (lc_en_o !== exp_en()) begin
                errors++;
                $display("FAIL random_en%0d: got %h want %h", i, lc_en_o, exp_en());
            end
            checks++;
            if (invalid_o !== exp_inv()) begin
                errors++;
                $display("FAIL random_inv%0d: got %b want %b", i, invalid_o, exp_inv());
            end
`ifdef LC_TX_SYNC_CHK_STICKY_ERR_EN
            checks++;
            if (err_sticky_o !== m_sticky) begin
                errors++;
                $display("FAIL random_sticky%0d: got %b want %b", i, err_sticky_o, m_sticky);
            end
`endif
        end
`ifdef LC_TX_SYNC_CHK_STICKY_ERR_EN
        err_clr = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_invalid();
        test_multich();
        test_async_reset();
`ifdef LC_TX_SYNC_CHK_STICKY_ERR_EN
        test_sticky();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
